// File: rtl/tilelink_a_arbiter.sv
// -----------------------------------------------------------------------------
// tilelink_a_arbiter
//
// Round-robin arbiter for the A channel of an M-to-1 TileLink junction.
// Each cycle it picks one requester and drives the one-hot and binary selects
// that steer the shared A-channel mux. A multi-beat burst locks the grant to
// its requester from the first accepted beat until the last one is accepted.
//
// Parameters
//   M      number of requesters (>= 2)
//   TL_DW  data width in bits (power of two, >= 8)
//   TL_SZ  width of the a_size field
//   IW     width of grant_idx_o
//
// Ports
//   tilelink_clock_i  clock; all state changes on the rising edge
//   tilelink_reset_i  synchronous, active-high reset
//   req_valid_i       per-requester a_valid
//   req_opcode_i      per-requester a_opcode, requester i at [3i+2:3i]
//   req_size_i        per-requester a_size (log2 bytes), TL_SZ bits each
//   a_ready_i         downstream slave a_ready
//   grant_o           one-hot grant (zero when nothing is granted)
//   grant_idx_o       binary index of the granted requester
//   grant_valid_o     granted requester's valid, routed to slave a_valid
//   req_ready_o       a_ready back to each requester (a_ready_i & grant_o[i])
//   locked_o          high while a burst holds the grant
// -----------------------------------------------------------------------------
module tilelink_a_arbiter #(
  parameter int M     = 2,
  parameter int TL_DW = 32,
  parameter int TL_SZ = 4,
  parameter int IW    = $clog2(M)
) (
  input  logic                 tilelink_clock_i,
  input  logic                 tilelink_reset_i,
  input  logic [M-1:0]         req_valid_i,
  input  logic [3*M-1:0]       req_opcode_i,
  input  logic [M*TL_SZ-1:0]   req_size_i,
  input  logic                 a_ready_i,
  output logic [M-1:0]         grant_o,
  output logic [IW-1:0]        grant_idx_o,
  output logic                 grant_valid_o,
  output logic [M-1:0]         req_ready_o,
  output logic                 locked_o
);

  // log2 of the bus width in bytes: sizes at or below this fit in one beat.
  localparam int LB = $clog2(TL_DW / 8);
  // 2**TL_SZ bits holds 2^(size-LB)-1 for every encodable size, so the
  // remaining-beat counter can never wrap.
  localparam int CW = 2 ** TL_SZ;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q,    state_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [IW-1:0]   lock_idx_q, lock_idx_d;
  logic [IW-1:0]   last_ptr_q, last_ptr_d;

  // Round-robin winner among the valid requesters
  logic            arb_found;
  logic [IW-1:0]   arb_idx;

  // Burst length information for the winner
  logic [2:0]      win_opcode;
  logic [TL_SZ-1:0] win_size;
  logic            win_is_data;
  logic [CW-1:0]   win_extra;   // beats - 1

  logic            accept;

  // ---------------------------------------------------------------------------
  // Round-robin search starting just after the last accepted requester.
  // ---------------------------------------------------------------------------
  always_comb begin
    int cand;
    cand      = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 1; k <= M; k++) begin
      cand = int'(last_ptr_q) + k;
      if (cand >= M) begin
        cand = cand - M;
      end
      if (!arb_found && req_valid_i[IW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IW'(cand);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Beat count of the winner's request. Only the data-carrying opcodes
  // (0..3) produce bursts, and only when the transfer exceeds one bus word.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_opcode  = req_opcode_i[3*arb_idx +: 3];
    win_size    = req_size_i[TL_SZ*arb_idx +: TL_SZ];
    win_is_data = (win_opcode < 3'd4);
    win_extra   = '0;
    if (win_is_data && (win_size > TL_SZ'(LB))) begin
      win_extra = (CW'(1) << (win_size - TL_SZ'(LB))) - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Grant outputs. In IDLE the grant follows the arbiter combinationally;
  // in LOCKED it is pinned to the burst owner regardless of its valid.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (state_q == LOCKED) begin
      grant_idx_o   = lock_idx_q;
      grant_valid_o = req_valid_i[lock_idx_q];
    end else begin
      grant_idx_o   = arb_idx;
      grant_valid_o = arb_found;
    end
  end

  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_grant
      assign grant_o[gi] = (state_q == LOCKED) ? (lock_idx_q == IW'(gi))
                                               : (arb_found && (arb_idx == IW'(gi)));
      assign req_ready_o[gi] = a_ready_i & grant_o[gi];
    end
  endgenerate

  assign locked_o = (state_q == LOCKED);
  assign accept   = grant_valid_o & a_ready_i;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lock_idx_d = lock_idx_q;
    last_ptr_d = last_ptr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Priority rotates only on accepts made by the arbiter itself.
          last_ptr_d = arb_idx;
          if (win_extra != '0) begin
            lock_idx_d = arb_idx;
            count_d    = win_extra;
            state_d    = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          if (count_q == CW'(1)) begin
            count_d = '0;
            state_d = IDLE;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. last_ptr resets to M-1 so requester 0 is searched first.
  // ---------------------------------------------------------------------------
  always_ff @(posedge tilelink_clock_i) begin
    if (tilelink_reset_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      lock_idx_q <= '0;
      last_ptr_q <= IW'(M - 1);
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      lock_idx_q <= lock_idx_d;
      last_ptr_q <= last_ptr_d;
    end
  end

endmodule

// File: tb/tb_tilelink_a_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tilelink_a_arbiter
//
// Directed bench for tilelink_a_arbiter (M=2, TL_DW=32, TL_SZ=4). A
// transaction-level model (last pointer, lock owner, beats remaining) predicts
// every output each cycle; directed steps also pin expected grant index and
// lock state with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_tilelink_a_arbiter;
  localparam int M     = 2;
  localparam int TL_DW = 32;
  localparam int TL_SZ = 4;
  localparam int IW    = 1;
  localparam int LB    = 2;

  localparam logic [2:0] PUTF  = 3'd0;
  localparam logic [2:0] ARITH = 3'd2;
  localparam logic [2:0] GET   = 3'd4;
  localparam logic [2:0] OP5   = 3'd5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [M-1:0]       valid;
  logic [3*M-1:0]     opcode;
  logic [M*TL_SZ-1:0] size;
  logic               a_ready;
  logic [M-1:0]       grant_o;
  logic [IW-1:0]      grant_idx_o;
  logic               grant_valid_o;
  logic [M-1:0]       req_ready_o;
  logic               locked_o;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int m_last   = M - 1;
  int m_locked = 0;
  int m_idx    = 0;
  int m_remain = 0;

  // Expected outputs
  int e_idx, e_gv, e_grant, e_rdy;

  tilelink_a_arbiter #(.M(M), .TL_DW(TL_DW), .TL_SZ(TL_SZ), .IW(IW)) dut (
    .tilelink_clock_i (clk),
    .tilelink_reset_i (rst),
    .req_valid_i      (valid),
    .req_opcode_i     (opcode),
    .req_size_i       (size),
    .a_ready_i        (a_ready),
    .grant_o          (grant_o),
    .grant_idx_o      (grant_idx_o),
    .grant_valid_o    (grant_valid_o),
    .req_ready_o      (req_ready_o),
    .locked_o         (locked_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int beats_of(input int i);
    int op, sz;
    op = int'(opcode[3*i +: 3]);
    sz = int'(size[TL_SZ*i +: TL_SZ]);
    if (op < 4 && sz > LB) return 1 << (sz - LB);
    return 1;
  endfunction

  function automatic int pick();
    int c;
    for (int k = 1; k <= M; k++) begin
      c = (m_last + k) % M;
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  // Model update on each rising edge
  always @(posedge clk) begin
    if (rst) begin
      m_last   <= M - 1;
      m_locked <= 0;
      m_idx    <= 0;
      m_remain <= 0;
    end else if (m_locked != 0) begin
      if (valid[m_idx] && a_ready) begin
        m_remain <= m_remain - 1;
        if (m_remain == 1) m_locked <= 0;
      end
    end else if (pick() >= 0 && a_ready) begin
      m_last <= pick();
      if (beats_of(pick()) > 1) begin
        m_locked <= 1;
        m_idx    <= pick();
        m_remain <= beats_of(pick()) - 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (m_locked != 0) begin
        e_idx   = m_idx;
        e_gv    = int'(valid[m_idx]);
        e_grant = 1 << m_idx;
      end else begin
        e_idx = pick();
        if (e_idx < 0) begin
          e_idx = 0; e_gv = 0; e_grant = 0;
        end else begin
          e_gv = 1; e_grant = 1 << e_idx;
        end
      end
      e_rdy = a_ready ? e_grant : 0;
      check("grant_o",       int'(grant_o),       e_grant);
      check("grant_idx_o",   int'(grant_idx_o),   e_idx);
      check("grant_valid_o", int'(grant_valid_o), e_gv);
      check("req_ready_o",   int'(req_ready_o),   e_rdy);
      check("locked_o",      int'(locked_o),      m_locked);
    end
  end

  task automatic drive(input logic [1:0] v, input logic [2:0] op0, input logic [3:0] s0,
                       input logic [2:0] op1, input logic [3:0] s1, input logic r);
    valid   = v;
    opcode  = {op1, op0};
    size    = {s1, s0};
    a_ready = r;
  endtask

  // One transaction cycle: literal checks at the falling edge (-1 skips).
  task automatic cyc(input string nm, input int ei, input int el);
    @(negedge clk);
    $display("cycle %-9s valid=%b rdy=%b grant=%b idx=%0d gv=%b lock=%b",
             nm, valid, a_ready, grant_o, grant_idx_o, grant_valid_o, locked_o);
    if (ei >= 0) check({nm, " idx"},  int'(grant_idx_o), ei);
    if (el >= 0) check({nm, " lock"}, int'(locked_o), el);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(2'b00, GET, 4'd2, GET, 4'd2, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state with nobody requesting
    @(negedge clk);
    check("reset grant_o", int'(grant_o), 0);
    check("reset gv",      int'(grant_valid_o), 0);
    check("reset ready",   int'(req_ready_o), 0);
    @(posedge clk);
    #1;
    cyc("reset", 0, 0);

    // Round-robin between two Get requesters
    drive(2'b11, GET, 4'd2, GET, 4'd2, 1'b1);
    cyc("rr0", 0, 0);
    cyc("rr1", 1, 0);
    cyc("rr0b", 0, 0);
    cyc("rr1b", 1, 0);

    // 4-beat PutFullData from req0, stall after beat 2, valid glitch
    drive(2'b11, PUTF, 4'd4, GET, 4'd2, 1'b1);
    cyc("b1", 0, 0);
    cyc("b2", 0, 1);
    drive(2'b11, PUTF, 4'd4, GET, 4'd2, 1'b0);
    cyc("stall1", 0, 1);
    cyc("stall2", 0, 1);
    cyc("stall3", 0, 1);
    drive(2'b10, PUTF, 4'd4, GET, 4'd2, 1'b1);
    @(negedge clk);
    check("vdrop gv",    int'(grant_valid_o), 0);
    check("vdrop grant", int'(grant_o), 1);
    @(posedge clk);
    #1;
    drive(2'b11, PUTF, 4'd4, GET, 4'd2, 1'b1);
    cyc("b3", 0, 1);
    cyc("b4", 0, 1);
    cyc("rel", 1, 0);

    // Single-beat PutFullData: no lock, pointer advances
    drive(2'b01, PUTF, 4'd2, GET, 4'd2, 1'b1);
    cyc("single", 0, 0);
    drive(2'b11, GET, 4'd2, GET, 4'd2, 1'b1);
    cyc("adv", 1, 0);

    // Stall in IDLE holds the grant and the pointer
    drive(2'b11, GET, 4'd2, GET, 4'd2, 1'b0);
    cyc("istall1", 0, 0);
    cyc("istall2", 0, 0);
    drive(2'b11, GET, 4'd2, GET, 4'd2, 1'b1);
    cyc("go", 0, 0);

    // 2-beat ArithmeticData from req1
    drive(2'b11, GET, 4'd2, ARITH, 4'd3, 1'b1);
    cyc("ar1", 1, 0);
    cyc("ar2", 1, 1);
    cyc("arrel", 0, 0);

    // Non-data opcode with a large size is single-beat
    drive(2'b10, GET, 4'd2, OP5, 4'd5, 1'b1);
    cyc("nd1", 1, 0);
    cyc("nd2", 1, 0);

    // Reset after beat 1 of an 8-beat burst
    drive(2'b11, PUTF, 4'd5, GET, 4'd2, 1'b1);
    cyc("r8b1", 0, 0);
    rst = 1'b1;
    cyc("rstlock", 0, 1);
    rst = 1'b0;
    drive(2'b11, GET, 4'd2, GET, 4'd2, 1'b1);
    cyc("postrst", 0, 0);
    cyc("postrst2", 1, 0);

    // Lone requester 1, Get size 6: zero-latency grant
    drive(2'b10, GET, 4'd2, GET, 4'd6, 1'b1);
    @(negedge clk);
    check("solo gv",    int'(grant_valid_o), 1);
    check("solo ready", int'(req_ready_o), 2);
    @(posedge clk);
    #1;
    cyc("solo", 1, 0);

    drive(2'b00, GET, 4'd2, GET, 4'd2, 1'b1);
    cyc("idle", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
